div_16_seq: RTL and testbench
=============================

# div_16_seq

Iterative unsigned 16-bit divider for the datapath, the inverse counterpart to the team's 16-bit carry-select adder: it computes quotient and remainder by restoring shift-subtract, one quotient bit per clock. It sits beside the ALU as a multi-cycle functional unit and talks to the control logic through a start/ready/done handshake. Results stay stable until the next accepted operation.

## Interface
Parameters:
- WIDTH, 16, operand/result width. Only 16 is verified; all widths below are WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- dividend  in  16  numerator, sampled on accept
- divisor  in  16  denominator, sampled on accept
- ready  out  1  high in IDLE; unit can accept start
- busy  out  1  high while iterating (RUN)
- done  out  1  one-cycle pulse; results valid from this cycle
- quotient  out  16  result, held until next accept
- remainder  out  16  result, held until next accept
- div_by_zero  out  1  set with done when divisor was 0; held like results

## Operation
- States: IDLE, RUN, DONE.
- Reset (any state, any time): state=IDLE; quotient=0, remainder=0, div_by_zero=0, done=0, busy=0, ready=1. Iteration counter=0. An in-flight operation is discarded with no done.
- IDLE: if start=1, latch divisor into D, clear div_by_zero.
  - divisor==0: quotient=16'hFFFF, remainder=dividend, div_by_zero=1, go to DONE.
  - else: Q=dividend, R=0 (17-bit), count=0, go to RUN.
- RUN, each edge: trial = {R[15:0], Q[15]} - {1'b0, D} (17 bits).
  - No borrow (trial[16]=0): R=trial, Q={Q[14:0],1}.
  - Borrow: R={R[15:0], Q[15]}, Q={Q[14:0],0}.
  - count increments; on the 16th iteration (count==15) go to DONE.
- DONE: done=1 for exactly one cycle; quotient=Q, remainder=R[15:0]. Next edge go to IDLE.
- start while RUN or DONE is ignored, not queued. Operand inputs are don't-care outside the accept edge.
- Outputs quotient/remainder/div_by_zero keep their last values through IDLE. During RUN they show the in-progress Q and R[15:0] and are not valid until done.

## Timing
- Accept edge E0 (start=1, ready=1). Normal divide: busy=1 in cycles 1–16, iterations on edges E1–E16, done=1 in cycle 17, ready=1 again from cycle 18. Total latency 17 cycles.
- Divide-by-zero: done=1 in cycle 1, ready=1 from cycle 2.
- ready is low from cycle 1 until done has been seen. Back-to-back operation accepts at the earliest in the cycle after done.
- If reset_n is asserted during the done cycle, done drops immediately (asynchronous) and all results are cleared.

## Structure
- Shared package div_pkg: state enum (IDLE, RUN, DONE), localparam WIDTH=16, localparam CNT_W=4.
- Sub-module sub_17: combinational 17-bit subtractor computing a + ~b + 1, with borrow = result[16]. It is instantiated once for the trial subtraction. Control FSM, counter and Q/R registers live in div_16_seq.

## Test plan
- 100 / 7 → quotient=14, remainder=2, div_by_zero=0, done exactly 17 cycles after accept, busy high for 16 cycles.
- 16'hFFFF / 1 → quotient=16'hFFFF, remainder=0. 16'hFFFF / 16'hFFFF → quotient=1, remainder=0.
- 3 / 10 → quotient=0, remainder=3. 0 / 5 → quotient=0, remainder=0.
- 5 / 0 → quotient=16'hFFFF, remainder=5, div_by_zero=1, done 1 cycle after accept. A following 9 / 3 clears div_by_zero and gives quotient=3, remainder=0.
- Start 50 / 5, then pulse start with 8 / 2 in cycle 5 → the second request is ignored; result is 10 r 0, done at cycle 17.
- Start 1000 / 3, assert reset_n=0 in cycle 8 → all outputs 0 and ready=1 at once, with no done. After release, 1000 / 3 gives 333 r 1.

Source files
------------

// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and sizing constants for the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : div_pkg

`default_nettype wire

// File: rtl/sub_17.sv
// ============================================================================
// Module   : sub_17
// Purpose  : Combinational two's-complement subtractor (a - b); borrow is the MSB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_17 #(
    parameter int W = 17
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    // Operands never exceed 2^(W-1) apart, so the MSB of a + ~b + 1 is the borrow.
    assign diff_o   = a_i + ~b_i + W'(1);
    assign borrow_o = diff_o[W-1];

endmodule : sub_17

`default_nettype wire

// File: rtl/div_16_seq.sv
// ============================================================================
// Module   : div_16_seq
// Purpose  : Restoring shift-subtract unsigned divider, one quotient bit/clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    import div_pkg::*;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    // R[WIDTH] of the 17-bit partial remainder is provably zero (R < D), so only
    // the low WIDTH bits are stored.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial_w;
    logic             borrow_w;

    sub_17 #(
        .W (WIDTH + 1)
    ) u_sub (
        .a_i      ({r_q, q_q[WIDTH-1]}),
        .b_i      ({1'b0, d_q}),
        .diff_o   (trial_w),
        .borrow_o (borrow_w)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    d_d   = divisor;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        q_d     = '1;
                        r_d     = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        q_d     = dividend;
                        r_d     = '0;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!borrow_w) begin
                    r_d = trial_w[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready       = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;

endmodule : div_16_seq

`default_nettype wire

// File: tb/tb_div_16_seq.sv
// ============================================================================
// Module   : tb_div_16_seq
// Purpose  : Self-checking directed-vector bench for div_16_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_16_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks;
    int errors;

    div_16_seq #(
        .WIDTH (16)
    ) dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_q;
        logic [15:0] exp_r;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and wait for done. Returns the cycle index
    // of done (accept edge = E0, cycle 1 follows it) and the busy-cycle count.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int busy_cnt);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = 16'hxxxx;
        divisor  = 16'hxxxx;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (ready) lat = 99;
            else begin
                tick();
                lat++;
            end
        end
    endtask

    vec_t vecs[9];
    int   lat, bc;

    initial begin
        checks   = 0;
        errors   = 0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        reset_n  = 1'b0;

        vecs[0] = '{16'd100,   16'd7,      16'd14,    16'd2,   1'b0, 17};
        vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF,  16'd0,   1'b0, 17};
        vecs[2] = '{16'hFFFF,  16'hFFFF,   16'd1,     16'd0,   1'b0, 17};
        vecs[3] = '{16'd3,     16'd10,     16'd0,     16'd3,   1'b0, 17};
        vecs[4] = '{16'd0,     16'd5,      16'd0,     16'd0,   1'b0, 17};
        vecs[5] = '{16'd5,     16'd0,      16'hFFFF,  16'd5,   1'b1, 1};
        vecs[6] = '{16'd9,     16'd3,      16'd3,     16'd0,   1'b0, 17};
        vecs[7] = '{16'd40000, 16'd123,    16'd325,   16'd25,  1'b0, 17};
        vecs[8] = '{16'h8000,  16'd2,      16'h4000,  16'd0,   1'b0, 17};

        repeat (2) tick();
        chk("rst_quotient",  {16'd0, quotient},  32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_ready",     {31'd0, ready},     32'd1);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, bc);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_busy_cycles", i), bc, (vecs[i].exp_lat == 17) ? 16 : 0);
            chk($sformatf("v%0d_quotient", i), {16'd0, quotient}, {16'd0, vecs[i].exp_q});
            chk($sformatf("v%0d_remainder", i), {16'd0, remainder}, {16'd0, vecs[i].exp_r});
            chk($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].exp_dbz});
            tick();
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d_ready_after", i), {31'd0, ready}, 32'd1);
            chk($sformatf("v%0d_hold_q", i), {16'd0, quotient}, {16'd0, vecs[i].exp_q});
            chk($sformatf("v%0d_hold_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].exp_dbz});
        end

        // Start pulse during RUN must be ignored.
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (lat == 5) begin
                start = 1'b1; dividend = 16'd8; divisor = 16'd2;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        chk("ign_latency",   lat, 17);
        chk("ign_quotient",  {16'd0, quotient},  32'd10);
        chk("ign_remainder", {16'd0, remainder}, 32'd0);
        tick();
        chk("ign_ready", {31'd0, ready}, 32'd1);

        // Reset mid-operation in cycle 8.
        start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_quotient",  {16'd0, quotient},  32'd0);
        chk("mid_remainder", {16'd0, remainder}, 32'd0);
        chk("mid_ready",     {31'd0, ready},     32'd1);
        chk("mid_busy",      {31'd0, busy},      32'd0);
        chk("mid_done",      {31'd0, done},      32'd0);
        tick();
        reset_n = 1'b1;
        bc = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) bc++;
        end
        chk("mid_no_done", bc, 0);
        run_op(16'd1000, 16'd3, lat, bc);
        chk("post_latency",   lat, 17);
        chk("post_quotient",  {16'd0, quotient},  32'd333);
        chk("post_remainder", {16'd0, remainder}, 32'd1);

        // Reset asserted during the done cycle.
        tick();
        run_op(16'd100, 16'd7, lat, bc);
        chk("dr_done_seen", {31'd0, done}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("dr_done",     {31'd0, done},      32'd0);
        chk("dr_quotient", {16'd0, quotient},  32'd0);
        chk("dr_ready",    {31'd0, ready},     32'd1);
        tick();
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_16_seq

`default_nettype wire
